sample_shift_out: RTL
=====================

SAMPLE_SHIFT_OUT -- requirements
Module: sample_shift_out

Interface
REQ-001 Parameter DATA_W, 16, sample width in bits (range 4..32).
REQ-002 Parameter CLK_DIV, 4, CLOCK cycles per SCLK half-period (range 1..255).
REQ-003 Parameter OFFSET_BIN, 0, 1 = convert two's complement to offset binary by inverting the MSB before shifting.
REQ-004 CLOCK  input  1  system clock; all logic on the rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 sample_rdy  input  1  one-cycle pulse: sample_in is valid and shall be captured.
REQ-007 sample_in  input  DATA_W  two's-complement interpolated sample from the FIR datapath.
REQ-008 shift_done  output  1  one-cycle pulse: the last bit of the frame is complete.
REQ-009 busy  output  1  high from capture until shift_done, inclusive.
REQ-010 overrun  output  1  one-cycle pulse when sample_rdy arrives while busy.
REQ-011 SCLK  output  1  serial bit clock to the DAC, registered.
REQ-012 SDATA  output  1  serial data, MSB first, registered.
REQ-013 FS  output  1  frame sync, high for exactly the first bit period of each frame.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; all other encodings shall go to IDLE.
REQ-015 IDLE: when sample_rdy=1 at edge T, capture sample_in (MSB inverted if OFFSET_BIN=1) into the shift register, clear the bit and divider counters, and enter SHIFT at T+1.
REQ-016 SHIFT: each bit period lasts 2*CLK_DIV cycles: SCLK=0 for the first CLK_DIV cycles and 1 for the next CLK_DIV cycles. SDATA shall be stable for the whole period, so the DAC samples on the SCLK rising edge.
REQ-017 SDATA shall equal the current MSB of the shift register. The register shifts left by one, zero-filled, at the end of each bit period.
REQ-018 FS=1 during bit period 0 only.
REQ-019 After bit period DATA_W-1 completes, enter DONE for exactly one cycle with shift_done=1, then return to IDLE.
REQ-020 Latency: shift_done is high at cycle T+1+2*CLK_DIV*DATA_W. With the defaults this is T+129.
REQ-021 sample_rdy in SHIFT or DONE shall be ignored: no capture, no effect on the frame in progress, and overrun=1 on the following cycle.
REQ-022 sample_rdy in IDLE on the cycle directly after DONE shall be accepted normally, allowing back-to-back frames.
REQ-023 In IDLE: SCLK=0, SDATA=0, FS=0, busy=0, shift_done=0.
REQ-024 The bit counter shall be sized to ceil(log2(DATA_W+1)) and the divider counter to ceil(log2(CLK_DIV+1)). Neither counter shall wrap inside a frame.

Reset
REQ-025 RESET=1 at any edge, including mid-frame, shall force IDLE, clear the shift register and counters, and drive all outputs to 0 on the next cycle.
REQ-026 A frame aborted by reset shall not produce shift_done.
REQ-027 RESET shall take priority over sample_rdy on the same edge.

Structure
REQ-028 The shared package shall hold: state encoding, default DATA_W and CLK_DIV, and the counter-width functions.
REQ-029 The sub-module sclk_divider shall generate the half-period tick and the bit-period-end tick from CLK_DIV, with a synchronous clear.
REQ-030 All outputs shall be driven directly from flops; no combinational path from an input to an output.

Verification
REQ-031 Reset release, then sample_in=16'h8001 with OFFSET_BIN=0 -> SDATA bits 1000_0000_0000_0001, FS high for the first 8 cycles, shift_done at T+129.
REQ-032 Same stimulus with OFFSET_BIN=1 -> bits 0000_0000_0000_0001.
REQ-033 sample_rdy repeated at T+50 -> overrun pulse at T+51, the original frame is unchanged, and exactly one shift_done.
REQ-034 RESET asserted at T+60 -> all outputs 0 at T+61, no shift_done, and the next sample_rdy starts a clean frame.
REQ-035 Back-to-back: second sample_rdy on the first IDLE cycle after DONE -> second frame starts with no gap, and FS reasserts.
REQ-036 CLK_DIV=1, DATA_W=4, sample_in=4'hA -> SCLK toggles every cycle, SDATA=1,0,1,0, shift_done at T+9.

Source files
------------

// File: rtl/sample_shift_out_pkg.sv
// Shared definitions for the sample_shift_out serialiser: FSM encoding,
// default geometry and counter-width helpers.
package sample_shift_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_CLK_DIV = 4;

  // Bit counter must be able to hold DATA_W itself, so it never wraps in a frame.
  function automatic int unsigned bit_cnt_width(input int unsigned data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int unsigned div_cnt_width(input int unsigned clk_div);
    return $clog2(clk_div + 1);
  endfunction

endpackage

// File: rtl/sample_shift_out_sclk_divider.sv
// Bit-clock divider: counts CLK_DIV cycles per SCLK half-period and flags
// the end of each half-period and of each full bit period.
module sclk_divider
  import sample_shift_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
)
(
  input  logic CLOCK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic bit_tick
);

  localparam int unsigned      DIV_W    = div_cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             second_half;

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      div_cnt     <= '0;
      second_half <= 1'b0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt     <= '0;
        second_half <= ~second_half;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    half_tick = enable && (div_cnt == DIV_LAST);
    bit_tick  = half_tick && second_half;
  end

endmodule

// File: rtl/sample_shift_out.sv
// Serialises one interpolated sample per frame to a DAC: MSB first on SDATA,
// bit clock on SCLK, frame sync on FS for the first bit period.
module sample_shift_out
  import sample_shift_out_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned OFFSET_BIN = 0
)
(
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              sample_rdy,
  input  logic [DATA_W-1:0] sample_in,
  output logic              shift_done,
  output logic              busy,
  output logic              overrun,
  output logic              SCLK,
  output logic              SDATA,
  output logic              FS
);

  localparam int unsigned      BIT_W    = bit_cnt_width(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DATA_W-1:0] capture_word;
  logic [BIT_W-1:0]  bit_cnt;
  logic              div_clear;
  logic              div_enable;
  logic              half_tick;
  logic              bit_tick;

  always_comb begin
    capture_word = sample_in;
    if (OFFSET_BIN != 0) begin
      capture_word[DATA_W-1] = ~sample_in[DATA_W-1];
    end
    shreg_next = shreg << 1;
    div_enable = (state == ST_SHIFT);
    div_clear  = (state != ST_SHIFT);
  end

  sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_divider (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .clear     (div_clear),
    .enable    (div_enable),
    .half_tick (half_tick),
    .bit_tick  (bit_tick)
  );

  // Outputs are loaded with the value for the coming cycle, so SDATA/FS/SCLK
  // are valid on the first SHIFT cycle straight from the capture edge.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      SCLK       <= 1'b0;
      SDATA      <= 1'b0;
      FS         <= 1'b0;
      busy       <= 1'b0;
      shift_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      shift_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          SCLK  <= 1'b0;
          SDATA <= 1'b0;
          FS    <= 1'b0;
          busy  <= 1'b0;
          if (sample_rdy) begin
            shreg   <= capture_word;
            bit_cnt <= '0;
            SDATA   <= capture_word[DATA_W-1];
            FS      <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          overrun <= sample_rdy;
          if (bit_tick) begin
            SCLK    <= 1'b0;
            FS      <= 1'b0;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
              SDATA      <= 1'b0;
              shift_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              SDATA <= shreg_next[DATA_W-1];
            end
          end else if (half_tick) begin
            SCLK <= 1'b1;
          end
        end

        ST_DONE: begin
          overrun <= sample_rdy;
          SCLK    <= 1'b0;
          SDATA   <= 1'b0;
          FS      <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= '0;
          state   <= ST_IDLE;
        end

        default: begin
          SCLK    <= 1'b0;
          SDATA   <= 1'b0;
          FS      <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= '0;
          shreg   <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
